// File: rtl/deser_pkg.sv
// Shared types and widths for the bit-serial receive deserializer.
package deser_pkg;
    typedef enum logic {FILL, FULL} deser_state_t;
    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;
endpackage

// File: rtl/decoder3_8.sv
// 3:8 one-hot decoder producing per-bit write enables for the data register.
// Latency: combinational. Backpressure: none, output is zero when en is low.
module decoder3_8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] out
);
    assign out = en ? (8'b0000_0001 << sel) : 8'b0000_0000;
endmodule

// File: rtl/deser8_1.sv
// Serial-to-parallel deserializer: one bit per accept, 8-bit word out on valid/ready.
// Latency: word valid the cycle after the 8th accepted bit; 1 bit/cycle sustained.
// Backpressure: while a full word waits, in_ready follows out_ready and nothing moves.
module deser8_1
    import deser_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] fill_count
);
    deser_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
    logic              full;
    logic              accept;
    logic              handshake;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  slot;
    logic [WORD_W-1:0] bit_we;

    assign full       = (state == FULL);
    assign in_ready   = full ? out_ready : 1'b1;
    assign out_valid  = full;
    assign out_data   = data;
    assign fill_count = full ? '0 : idx;

    assign accept    = in_valid & in_ready;
    assign handshake = full & out_ready;
    // clear only matters while filling; a completed word is never discarded
    assign wr_en     = accept & (full | ~clear);
    // a bit accepted alongside delivery is the first bit of the next word
    assign wr_idx    = full ? '0 : idx;
    assign slot      = (LSB_FIRST != 0) ? wr_idx : (IDX_W'(WORD_W - 1) - wr_idx);

    decoder3_8 u_dec (
        .en  (wr_en),
        .sel (slot),
        .out (bit_we)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FILL;
            idx   <= '0;
            data  <= '0;
        end else begin
            for (int i = 0; i < WORD_W; i++) begin
                if (bit_we[i]) data[i] <= in_bit;
            end
            case (state)
                FILL: begin
                    if (clear) begin
                        idx <= '0;
                    end else if (accept) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(WORD_W - 1)) state <= FULL;
                    end
                end
                FULL: begin
                    if (handshake) begin
                        state <= FILL;
                        idx   <= accept ? IDX_W'(1) : '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_deser8_1.sv
// Bench for deser8_1: LSB-first and MSB-first instances driven in parallel against a queue model.
module tb_deser8_1;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_bit, in_valid, clear, out_ready;
    logic       rdy1, vld1, rdy0, vld0;
    logic [7:0] dat1, dat0;
    logic [2:0] fc1, fc0;

    deser8_1 #(.LSB_FIRST(1)) dut_lsb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy1),
        .clear(clear), .out_data(dat1), .out_valid(vld1), .out_ready(out_ready), .fill_count(fc1));

    deser8_1 #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy0),
        .clear(clear), .out_data(dat0), .out_valid(vld0), .out_ready(out_ready), .fill_count(fc0));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: list of accepted bits of the current word plus a pending-word flag.
    bit         m_full = 1'b0;
    bit         m_q[$];
    logic [7:0] m_w1, m_w0;

    task automatic tick();
        bit acc;
        acc = in_valid && (!m_full || out_ready);
        if (!reset) begin
            m_full = 1'b0;
            m_q.delete();
        end else if (m_full) begin
            if (out_ready) begin
                m_full = 1'b0;
                m_q.delete();
                if (acc) m_q.push_back(in_bit);
            end
        end else if (clear) begin
            m_q.delete();
        end else if (acc) begin
            m_q.push_back(in_bit);
            if (m_q.size() == 8) begin
                m_w1 = 8'h00;
                m_w0 = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    m_w1[k]     = m_q[k];
                    m_w0[7 - k] = m_q[k];
                end
                m_full = 1'b1;
                m_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic flush();
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_bit = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        n_checks++; if (vld1 !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", vld1); end
        n_checks++; if (fc1 !== 3'd0)   begin n_fail++; $display("FAIL reset_fill_count got %0d want 0", fc1); end
        n_checks++; if (dat1 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", dat1); end
        n_checks++; if (rdy1 !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy1); end
        n_checks++; if (vld0 !== 1'b0 || dat0 !== 8'h00) begin n_fail++; $display("FAIL reset_msb got vld=%b data=%h want 0/00", vld0, dat0); end
    endtask

    task automatic test_basic_byte();
        logic [7:0] pat;
        pat = 8'b0100_1101;
        flush();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = pat[i];
            tick();
            if (i < 7) begin
                n_checks++; if (fc1 !== 3'(i + 1)) begin n_fail++; $display("FAIL basic_fill_count bit %0d got %0d want %0d", i, fc1, i + 1); end
                n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid bit %0d got %b want 0", i, vld1); end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (vld1 !== 1'b1)  begin n_fail++; $display("FAIL basic_valid got %b want 1", vld1); end
        n_checks++; if (dat1 !== 8'h4D) begin n_fail++; $display("FAIL basic_lsb_word got %h want 4d", dat1); end
        n_checks++; if (dat0 !== 8'hB2) begin n_fail++; $display("FAIL basic_msb_word got %h want b2", dat0); end
        n_checks++; if (fc1 !== 3'd0)   begin n_fail++; $display("FAIL basic_full_count got %0d want 0", fc1); end
        tick();
        n_checks++; if (vld1 !== 1'b0)  begin n_fail++; $display("FAIL basic_valid_one_cycle got %b want 0", vld1); end
    endtask

    task automatic test_streaming();
        logic [7:0] words [4];
        int last, nw;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
        last = -1;
        nw   = 0;
        flush();
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_bit = words[i / 8][i % 8];
            tick();
            n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cycle %0d got %b want 1", i, rdy1); end
            n_checks++; if (vld1 !== m_full) begin n_fail++; $display("FAIL stream_valid cycle %0d got %b want %b", i, vld1, m_full); end
            if (vld1 === 1'b1 && nw < 4) begin
                n_checks++; if (dat1 !== words[nw]) begin n_fail++; $display("FAIL stream_word %0d got %h want %h", nw, dat1, words[nw]); end
                n_checks++; if (dat0 !== m_w0) begin n_fail++; $display("FAIL stream_msb_word %0d got %h want %h", nw, dat0, m_w0); end
                if (last >= 0) begin
                    n_checks++; if (cyc - last != 8) begin n_fail++; $display("FAIL stream_spacing word %0d got %0d want 8", nw, cyc - last); end
                end
                last = cyc;
                nw++;
            end
        end
        n_checks++; if (nw != 4) begin n_fail++; $display("FAIL stream_word_count got %0d want 4", nw); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [7:0] pat;
        pat = 8'h5A;
        flush();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_bit = pat[i];
            tick();
        end
        out_ready = 1'b0;
        in_bit    = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_checks++; if (rdy1 !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready stall %0d got %b want 0", j, rdy1); end
            n_checks++; if (vld1 !== 1'b1)  begin n_fail++; $display("FAIL bp_valid stall %0d got %b want 1", j, vld1); end
            n_checks++; if (dat1 !== 8'h5A) begin n_fail++; $display("FAIL bp_data stall %0d got %h want 5a", j, dat1); end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (fc1 !== 3'd1) begin n_fail++; $display("FAIL bp_release_count got %0d want 1", fc1); end
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", vld1); end
        n_checks++; if (dat1[0] !== 1'b1 || dat0[7] !== 1'b1) begin n_fail++; $display("FAIL bp_first_slot got lsb=%b msb=%b want 1/1", dat1[0], dat0[7]); end
    endtask

    task automatic test_clear();
        logic [7:0] exp, rev;
        flush();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++; if (fc1 !== 3'd5) begin n_fail++; $display("FAIL clear_pre_count got %0d want 5", fc1); end
        clear  = 1'b1;
        in_bit = 1'($urandom_range(0, 1));
        tick();
        clear = 1'b0;
        n_checks++; if (fc1 !== 3'd0 || fc0 !== 3'd0) begin n_fail++; $display("FAIL clear_count got %0d/%0d want 0", fc1, fc0); end
        for (int i = 0; i < 8; i++) begin
            exp[i] = 1'($urandom_range(0, 1));
            in_bit = exp[i];
            tick();
        end
        rev = {<<{exp}};
        n_checks++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL clear_word_valid got %b want 1", vld1); end
        n_checks++; if (dat1 !== exp)  begin n_fail++; $display("FAIL clear_word_lsb got %h want %h", dat1, exp); end
        n_checks++; if (dat0 !== rev)  begin n_fail++; $display("FAIL clear_word_msb got %h want %h", dat0, rev); end
        out_ready = 1'b0;
        clear     = 1'b1;
        tick();
        tick();
        n_checks++; if (vld1 !== 1'b1 || dat1 !== exp) begin n_fail++; $display("FAIL clear_in_full got vld=%b data=%h want 1/%h", vld1, dat1, exp); end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL clear_delivered got %b want 0", vld1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        pat = 8'hC3;
        flush();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_bit = 1'b1;
            tick();
        end
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        n_checks++; if (vld1 !== 1'b0 || fc1 !== 3'd0) begin n_fail++; $display("FAIL rstmid_fill_state got vld=%b cnt=%0d want 0/0", vld1, fc1); end
        n_checks++; if (dat1 !== 8'h00 || dat0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_fill_data got %h/%h want 00", dat1, dat0); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_fill_ready got %b want 1", rdy1); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_bit = pat[i];
            tick();
        end
        n_checks++; if (vld1 !== 1'b1 || dat1 !== 8'hC3) begin n_fail++; $display("FAIL rstmid_full_pre got vld=%b data=%h want 1/c3", vld1, dat1); end
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        n_checks++; if (vld1 !== 1'b0 || fc1 !== 3'd0) begin n_fail++; $display("FAIL rstmid_full_state got vld=%b cnt=%0d want 0/0", vld1, fc1); end
        n_checks++; if (dat1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_full_data got %h want 00", dat1); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_full_ready got %b want 1", rdy1); end
    endtask

    task automatic test_sparse();
        logic [7:0] exp, rev;
        int acc, t;
        acc = 0;
        t   = 0;
        exp = 8'h00;
        flush();
        while (acc < 8 && t < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            if (in_valid) begin
                exp[acc] = in_bit;
                acc++;
            end
            tick();
            t++;
            if (acc < 8) begin
                n_checks++; if (fc1 !== 3'(acc) || fc1 !== 3'(m_q.size())) begin n_fail++; $display("FAIL sparse_count step %0d got %0d want %0d", t, fc1, acc); end
                n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL sparse_early_valid step %0d got %b want 0", t, vld1); end
            end
        end
        in_valid = 1'b0;
        rev = {<<{exp}};
        n_checks++;
        if (acc < 8) begin
            n_fail++; $display("FAIL sparse_timeout got %0d accepts want 8", acc);
        end else if (vld1 !== 1'b1 || dat1 !== exp || dat0 !== rev) begin
            n_fail++; $display("FAIL sparse_word got vld=%b lsb=%h msb=%h want 1/%h/%h", vld1, dat1, dat0, exp, rev);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_streaming();
        test_back_pressure();
        test_clear();
        test_reset_mid();
        test_sparse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
